// File: rtl/mavg_peak_types.sv
// Shared types for the moving-sum peak detector: FSM states, event record
// and the widened compare helper.
package mavg_peak_types;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } state_t;

  localparam int CMP_W    = 10;
  localparam int TS_W_DEF = 16;

  typedef struct packed {
    logic signed [7:0]     val;
    logic [TS_W_DEF-1:0]   ts;
  } peak_evt_t;

  // Widen a sample so threshold arithmetic cannot wrap at +/-128.
  function automatic logic signed [CMP_W-1:0] sext(input logic signed [7:0] x);
    return {{(CMP_W-8){x[7]}}, x};
  endfunction

endpackage

// File: rtl/mavg_peak_hold.sv
// One-entry valid/ready hold buffer; a new event is dropped (and flagged)
// only when the held one is not leaving in the same cycle.
module mavg_peak_hold #(
  parameter int W = 24
) (
  input  logic         system1000,
  input  logic         system1000_rstn,
  input  logic         evt_vld_i,
  input  logic [W-1:0] evt_data_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic         overflow_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic         consume;

  assign consume = vld_q && rdy_i;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (evt_vld_i) begin
      if (!vld_q || consume) begin
        vld_d  = 1'b1;
        data_d = evt_data_i;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (consume) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign vld_o      = vld_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mavg_peak_detect.sv
// Hysteresis peak detector on the filtered sample stream; confirmed peaks
// leave as (value, timestamp) events through a one-entry hold buffer.
module mavg_peak_detect
  import mavg_peak_types::*;
#(
  parameter int HYST = 8,
  parameter int TS_W = 16
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic signed [7:0]   sample_i,
  input  logic                sample_vld_i,
  output logic                peak_vld_o,
  input  logic                peak_rdy_i,
  output logic signed [7:0]   peak_val_o,
  output logic [TS_W-1:0]     peak_ts_o,
  output logic                overflow_o,
  output logic [1:0]          state_o
);

  localparam int EVT_W = 8 + TS_W;
  localparam logic signed [CMP_W-1:0] HYST_C = CMP_W'(HYST);

  state_t                   state_q;
  logic [TS_W-1:0]          ts_q;
  logic [TS_W-1:0]          max_ts_q;
  logic signed [7:0]        max_q;
  logic signed [7:0]        min_q;

  logic signed [CMP_W-1:0]  samp_x, max_x, min_x;
  logic                     new_max, fall_hit, new_min, rise_hit;
  logic                     evt_fire;
  logic [EVT_W-1:0]         evt_data;
  logic [EVT_W-1:0]         hold_data;

  assign samp_x   = sext(sample_i);
  assign max_x    = sext(max_q);
  assign min_x    = sext(min_q);
  assign new_max  = samp_x > max_x;
  assign fall_hit = samp_x <= (max_x - HYST_C);
  assign new_min  = samp_x < min_x;
  assign rise_hit = samp_x >= (min_x + HYST_C);

  // A non-strict rise keeps the earlier max_ts, so ties never refresh it.
  assign evt_fire = sample_vld_i && (state_q == ST_RISE) && !new_max && fall_hit;
  assign evt_data = {max_q, max_ts_q};

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q  <= ST_INIT;
      ts_q     <= '0;
      max_ts_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
    end else if (sample_vld_i) begin
      ts_q <= ts_q + 1'b1;
      case (state_q)
        ST_INIT: begin
          max_q    <= sample_i;
          min_q    <= sample_i;
          max_ts_q <= ts_q;
          state_q  <= ST_RISE;
        end
        ST_RISE: begin
          if (new_max) begin
            max_q    <= sample_i;
            max_ts_q <= ts_q;
          end else if (fall_hit) begin
            min_q   <= sample_i;
            state_q <= ST_FALL;
          end
        end
        ST_FALL: begin
          if (new_min) begin
            min_q <= sample_i;
          end else if (rise_hit) begin
            max_q    <= sample_i;
            max_ts_q <= ts_q;
            state_q  <= ST_RISE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  mavg_peak_hold #(.W(EVT_W)) u_hold (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .evt_vld_i       (evt_fire),
    .evt_data_i      (evt_data),
    .rdy_i           (peak_rdy_i),
    .vld_o           (peak_vld_o),
    .data_o          (hold_data),
    .overflow_o      (overflow_o)
  );

  assign peak_val_o = hold_data[EVT_W-1 -: 8];
  assign peak_ts_o  = hold_data[TS_W-1:0];
  assign state_o    = state_q;

endmodule

// File: tb/tb_mavg_peak_detect.sv
// Vector table drives the detector; expected events go to a queue and are
// checked when the DUT hands them over.
module tb_mavg_peak_detect;

  logic              clk;
  logic              rstn;
  logic signed [7:0] sample;
  logic              sample_vld;
  logic              peak_vld;
  logic              peak_rdy;
  logic signed [7:0] peak_val;
  logic [15:0]       peak_ts;
  logic              overflow;
  logic [1:0]        state;

  mavg_peak_detect #(.HYST(8), .TS_W(16)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .sample_i        (sample),
    .sample_vld_i    (sample_vld),
    .peak_vld_o      (peak_vld),
    .peak_rdy_i      (peak_rdy),
    .peak_val_o      (peak_val),
    .peak_ts_o       (peak_ts),
    .overflow_o      (overflow),
    .state_o         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              vld;
    logic signed [7:0] s;
    logic              rdy;
    logic              evt;
    logic signed [7:0] ev_val;
    logic [15:0]       ev_ts;
    logic              exp_vld;
    logic signed [7:0] hv_val;
    logic [15:0]       hv_ts;
    logic              exp_ovf;
    logic [1:0]        exp_st;
    logic              rst_after;
  } vec_t;

  typedef struct {
    logic signed [7:0] val;
    logic [15:0]       ts;
  } evt_t;

  vec_t vecs[$];
  evt_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input int s, input logic r, input logic e,
                     input int ev, input int ets, input logic xv, input int hv,
                     input int hts, input logic xo, input int st, input logic ra);
    vec_t t;
    t.vld = v; t.s = 8'(s); t.rdy = r; t.evt = e; t.ev_val = 8'(ev);
    t.ev_ts = 16'(ets); t.exp_vld = xv; t.hv_val = 8'(hv); t.hv_ts = 16'(hts);
    t.exp_ovf = xo; t.exp_st = 2'(st); t.rst_after = ra;
    vecs.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"},   int'(peak_vld), 0);
    chk({tag, "_val"},   int'(peak_val), 0);
    chk({tag, "_ts"},    int'(peak_ts),  0);
    chk({tag, "_ovf"},   int'(overflow), 0);
    chk({tag, "_state"}, int'(state),    0);
  endtask

  // Reset asserted mid low-phase: outputs must clear with no clock edge.
  task automatic do_reset(input int idx);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs($sformatf("rst%0d", idx));
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic step(input int idx, input vec_t t);
    evt_t e;
    sample     = t.s;
    sample_vld = t.vld;
    peak_rdy   = t.rdy;
    if (t.evt) begin
      e.val = t.ev_val;
      e.ts  = t.ev_ts;
      sb.push_back(e);
    end
    #1;
    if (peak_vld && peak_rdy) begin
      if (sb.size() == 0) begin
        chk($sformatf("v%0d_unexpected_evt", idx), 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_hs_val", idx), int'(peak_val), int'(e.val));
        chk($sformatf("v%0d_hs_ts", idx),  int'(peak_ts),  int'(e.ts));
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_state", idx), int'(state),    int'(t.exp_st));
    chk($sformatf("v%0d_vld", idx),   int'(peak_vld), int'(t.exp_vld));
    chk($sformatf("v%0d_ovf", idx),   int'(overflow), int'(t.exp_ovf));
    if (t.exp_vld) begin
      chk($sformatf("v%0d_held_val", idx), int'(peak_val), int'(t.hv_val));
      chk($sformatf("v%0d_held_ts", idx),  int'(peak_ts),  int'(t.hv_ts));
    end
    $display("[TB] v%0d vld=%0b s=%0d rdy=%0b -> state=%0d pvld=%0b val=%0d ts=%0d ovf=%0b",
             idx, t.vld, t.s, t.rdy, state, peak_vld, peak_val, peak_ts, overflow);
    @(negedge clk);
  endtask

  initial begin
    rstn       = 1'b0;
    sample     = '0;
    sample_vld = 1'b0;
    peak_rdy   = 1'b0;

    // Ramp 0,4,10,20,15,11: event (20,3) after 11.
    add(1,   0, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,   4, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  10, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  20, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  15, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  11, 1, 1, 20, 3, 1, 20, 3, 0, 2, 0);
    add(0,   0, 1, 0,  0, 0, 0,  0, 0, 0, 2, 1);
    // Sub-hysteresis noise: stays in RISE, no event.
    add(1,  10, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,   5, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  10, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,   5, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  10, 1, 0,  0, 0, 0,  0, 0, 0, 1, 1);
    // Backpressure: (30,1) held, (40,3) dropped, overflow sticky until reset.
    add(1,   0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  30, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  20, 0, 1, 30, 1, 1, 30, 1, 0, 2, 0);
    add(1,  40, 0, 0,  0, 0, 1, 30, 1, 0, 1, 0);
    add(1,  30, 0, 0,  0, 0, 1, 30, 1, 1, 2, 0);
    add(0,   0, 1, 0,  0, 0, 0,  0, 0, 1, 2, 0);
    add(0,   0, 1, 0,  0, 0, 0,  0, 0, 1, 2, 1);
    // Extremes plus simultaneous consume and reload.
    add(1, 127, 1, 0,   0, 0, 0,   0, 0, 0, 1, 0);
    add(1,-128, 0, 1, 127, 0, 1, 127, 0, 0, 2, 0);
    add(1,-128, 0, 0,   0, 0, 1, 127, 0, 0, 2, 0);
    add(1, 127, 1, 0,   0, 0, 0,   0, 0, 0, 1, 0);
    add(1, 100, 0, 1, 127, 3, 1, 127, 3, 0, 2, 0);
    add(1, -50, 0, 0,   0, 0, 1, 127, 3, 0, 2, 0);
    add(1,   0, 0, 0,   0, 0, 1, 127, 3, 0, 1, 0);
    add(1, -10, 1, 1,   0, 6, 1,   0, 6, 0, 2, 0);
    add(0,   0, 1, 0,   0, 0, 0,   0, 0, 0, 2, 1);
    // Gaps and tie: invalid cycles carry bait values; event (9,1).
    add(1,   5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0,  99, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1,   9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0,  -7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1,   9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1,   0, 1, 1, 9, 1, 1, 9, 1, 0, 2, 0);
    // Held event discarded by a mid-stream reset.
    add(0,   0, 0, 0, 0, 0, 1, 9, 1, 0, 2, 1);
    // After reset ts restarts at 0.
    add(1,  50, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0);
    add(1,  40, 1, 1, 50, 0, 1, 50, 0, 0, 2, 0);
    add(0,   0, 1, 0,  0, 0, 0,  0, 0, 0, 2, 0);

    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i]);
      if (vecs[i].rst_after) begin
        if (!vecs[i].exp_vld)
          chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
        do_reset(i);
      end
    end
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mavg_peak_detect.md
# mavg_peak_detect

Downstream consumer of the 3-tap moving-sum stage: takes the signed 8-bit filtered sample stream and detects local peaks with hysteresis. For each confirmed peak it emits one event holding the peak value and a sample-count timestamp, through a valid/ready output with a one-entry hold buffer. It turns the continuous filtered signal into sparse events for control or logging logic.

## Interface
- HYST, 8, hysteresis in LSBs (1..127); a peak is confirmed when the signal falls HYST below the running max.
- TS_W, 16, timestamp counter width.
- system1000  in  1  clock, rising edge.
- system1000_rstn  in  1  reset system1000_rstn, asynchronous, active-low.
- sample_i  in  signed 8  filtered sample (moving-sum output).
- sample_vld_i  in  1  sample_i valid this cycle; tie high for a continuous stream.
- peak_vld_o  out  1  event available.
- peak_rdy_i  in  1  consumer accepts the event when peak_vld_o && peak_rdy_i.
- peak_val_o  out  signed 8  peak value.
- peak_ts_o  out  TS_W  timestamp of the sample that set the peak.
- overflow_o  out  1  sticky: an event was dropped; cleared only by reset.
- state_o  out  2  current detector state, for debug.

## Operation
- Timestamp counter ts: +1 per valid sample, wraps mod 2^TS_W. The first sample after reset has ts 0.
- States: INIT(0), RISE(1), FALL(2).
- INIT: first valid sample sets max = min = sample and max_ts = ts, then go to RISE.
- RISE:
  - sample > max: max = sample, max_ts = ts.
  - Ties keep the earlier max_ts.
  - Else if sample <= max − HYST: emit event (max, max_ts), set min = sample, go to FALL.
- FALL:
  - sample < min: min = sample.
  - Else if sample >= min + HYST: set max = sample, max_ts = ts, go to RISE. No event is emitted.
- Arithmetic: all threshold compares are done sign-extended to 10 bits, so no wrap occurs at ±128. The input itself is taken as-is; it has already wrapped upstream.
- Samples with sample_vld_i low change no state and do not advance ts.
- Hold buffer (one entry):
  - A new event loads the buffer when it is empty, or when it is being consumed in the same cycle.
  - Otherwise the new event is dropped and overflow_o is set. The held event is kept.

## Timing
- Reset (asynchronous, effective immediately):
  - state = INIT; ts, max, min, max_ts = 0.
  - peak_vld_o = 0, peak_val_o = 0, peak_ts_o = 0, overflow_o = 0, state_o = 0.
- Latency: the event appears on peak_vld_o the cycle after the edge that samples the triggering input.
- peak_vld_o stays high, with peak_val_o/peak_ts_o stable, until the cycle after the handshake.
- Back-to-back peaks need at least 2 valid samples between events, so the buffer sustains one event per cycle with peak_rdy_i high.
- Simultaneous consume and new event: the buffer reloads and peak_vld_o stays high. No overflow.
- Reset mid-operation: a pending event is discarded. No handshake completes on the reset edge.

## Structure
- Package mavg_peak_types holds:
  - state enum (INIT, RISE, FALL);
  - packed struct peak_evt_t {signed 8 val; TS_W ts};
  - 10-bit compare width localparam.
- Sub-module mavg_peak_hold implements the one-entry valid/ready buffer with overflow flag. The top level holds the FSM, the ts counter and the compare logic.

## Test plan
- Reset:
  - Stimulus: assert reset mid-stream.
  - Response: all outputs 0 asynchronously; state_o = 0.
- Ramp, HYST=8, rdy=1:
  - Stimulus: samples 0,4,10,20,15,11.
  - Response: single event val 20, ts 3, one cycle after 11 is sampled; state_o = FALL.
- Sub-hysteresis noise:
  - Stimulus: 10,5,10,5,10.
  - Response: no event; state_o stays RISE.
- Backpressure:
  - Stimulus: rdy=0; 0,30,20,40,30.
  - Response: event (30, ts1) held; second peak (40, ts3) dropped; overflow_o = 1. Raise rdy: one handshake, then peak_vld_o = 0.
- Extremes:
  - Stimulus: 127 then −128.
  - Response: event val 127. Then −128, 127 re-enters RISE with no event and no compare wrap.
- Gaps and tie:
  - Stimulus: sample_vld_i toggling; 5,9,9,0 on valid cycles only.
  - Response: ts counts valid samples only; event val 9, ts 1 (earlier tie kept).
